// File: rtl/gf_const_mult_column_seq.sv
// GF(2^M) constant-multiplier column: loads one coefficient and emits P products per enabled
// cycle for NCYC batches, stepping the running value by alpha^(J*P) between batches.
module gf_const_mult_column_seq #(
    parameter int unsigned M    = 13,
    parameter logic [M-1:0] POLY = 13'h001B,
    parameter int unsigned P    = 8,
    parameter int unsigned J    = 1,
    parameter int unsigned NCYC = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [M-1:0]   coef_i,
    input  logic           en_i,
    output logic           ready_o,
    output logic [P*M-1:0] prod_o,
    output logic           valid_o,
    output logic           last_o
);

    localparam int unsigned CW       = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);
    localparam int unsigned ORD      = (1 << M) - 1;

    // mat_t[j] is the image of basis element alpha^j, so x*c = XOR of columns selected by x.
    typedef logic [M-1:0][M-1:0] mat_t;
    typedef mat_t [P:0]          mat_bank_t;

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    function automatic logic [M-1:0] xtime(input logic [M-1:0] x);
        logic [M-1:0] r;
        r = {x[M-2:0], 1'b0};
        if (x[M-1]) begin
            r = r ^ POLY;
        end
        return r;
    endfunction

    function automatic mat_t gen_mat(input int unsigned e);
        mat_t        m;
        logic [M-1:0] col;
        int unsigned  er;
        er = e % ORD;
        for (int unsigned j = 0; j < M; j++) begin
            col = '0;
            col[j] = 1'b1;
            for (int unsigned n = 0; n < er; n++) begin
                col = xtime(col);
            end
            m[j] = col;
        end
        return m;
    endfunction

    // Entries 0..P-1 are the per-product constants, entry P is the batch advance constant.
    function automatic mat_bank_t gen_bank();
        mat_bank_t b;
        for (int unsigned i = 0; i < P; i++) begin
            b[i] = gen_mat(J * (i + 1));
        end
        b[P] = gen_mat(J * P);
        return b;
    endfunction

    function automatic logic [M-1:0] mat_mul(input mat_t mat, input logic [M-1:0] x);
        logic [M-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < M; j++) begin
            if (x[j]) begin
                r = r ^ mat[j];
            end
        end
        return r;
    endfunction

    localparam mat_bank_t MATS = gen_bank();

    state_t           state_q, state_d;
    logic [M-1:0]     acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [P*M-1:0]   prod_q, prod_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic [P*M-1:0]   prod_calc;
    logic [M-1:0]     acc_adv;

    always_comb begin
        prod_calc = '0;
        for (int unsigned i = 0; i < P; i++) begin
            prod_calc[i*M +: M] = mat_mul(MATS[i], acc_q);
        end
        acc_adv = mat_mul(MATS[P], acc_q);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_i) begin
                    acc_d   = coef_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // load_i is deliberately not looked at here: a run cannot be restarted.
                if (en_i) begin
                    prod_d  = prod_calc;
                    acc_d   = acc_adv;
                    cnt_d   = cnt_q + CW'(1);
                    valid_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        last_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // ready_o follows the state directly so a load is accepted in the last_o cycle.
    assign ready_o = (state_q == StIdle);
    assign prod_o  = prod_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_gf_const_mult_column_seq.sv
// Directed bench for gf_const_mult_column_seq: vector table on the default column plus
// multi-cycle sequences and a parameter sweep against a bit-serial GF model.
module tb_gf_const_mult_column_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic          load0 = 1'b0;
    logic [12:0]   coef0 = '0;
    logic          en0 = 1'b0;
    logic          ready0, valid0, last0;
    logic [103:0]  prod0;

    // M=8, POLY=1D, P=4, J=3, NCYC=2
    logic          load1 = 1'b0;
    logic [7:0]    coef1 = '0;
    logic          en1 = 1'b0;
    logic          ready1, valid1, last1;
    logic [31:0]   prod1;

    // Defaults with J=5
    logic          load2 = 1'b0;
    logic [12:0]   coef2 = '0;
    logic          en2 = 1'b0;
    logic          ready2, valid2, last2;
    logic [103:0]  prod2;

    gf_const_mult_column_seq u_dut0 (
        .clk(clk), .rst(rst), .load_i(load0), .coef_i(coef0), .en_i(en0),
        .ready_o(ready0), .prod_o(prod0), .valid_o(valid0), .last_o(last0)
    );

    gf_const_mult_column_seq #(.M(8), .POLY(8'h1D), .P(4), .J(3), .NCYC(2)) u_dut1 (
        .clk(clk), .rst(rst), .load_i(load1), .coef_i(coef1), .en_i(en1),
        .ready_o(ready1), .prod_o(prod1), .valid_o(valid1), .last_o(last1)
    );

    gf_const_mult_column_seq #(.J(5)) u_dut2 (
        .clk(clk), .rst(rst), .load_i(load2), .coef_i(coef2), .en_i(en2),
        .ready_o(ready2), .prod_o(prod2), .valid_o(valid2), .last_o(last2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [12:0]  coef;
        int           k;
        logic [103:0] exp;
    } vec_t;

    vec_t         vecs [6];
    logic [103:0] got0 [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [103:0] got, input logic [103:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] gmul(input logic [31:0] a, input logic [31:0] b,
                                         input int m, input logic [31:0] poly);
        logic [31:0] r;
        r = '0;
        for (int bi = m - 1; bi >= 0; bi--) begin
            r = r << 1;
            if (r[m]) r = (r ^ (32'd1 << m)) ^ poly;
            if (b[bi]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [31:0] apow(input int e, input int m, input logic [31:0] poly);
        logic [31:0] r;
        r = 32'd1;
        for (int n = 0; n < e; n++) r = gmul(r, 32'd2, m, poly);
        return r;
    endfunction

    // Full coefficient on the default instance, collecting all four batches.
    task automatic run_coef(input logic [12:0] c);
        load0 = 1'b1;
        coef0 = c;
        step();
        load0 = 1'b0;
        check("ready_low_after_load", {103'd0, ready0}, 104'd0);
        en0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            got0[k] = prod0;
            check($sformatf("valid_b%0d", k), {103'd0, valid0}, 104'd1);
            check($sformatf("last_b%0d", k), {103'd0, last0}, {103'd0, k == 3});
            check($sformatf("ready_b%0d", k), {103'd0, ready0}, {103'd0, k == 3});
        end
        en0 = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{13'h0001, 0, {13'h0100, 13'h0080, 13'h0040, 13'h0020,
                                  13'h0010, 13'h0008, 13'h0004, 13'h0002}};
        vecs[1] = '{13'h0001, 1, {13'h00D8, 13'h006C, 13'h0036, 13'h001B,
                                  13'h1000, 13'h0800, 13'h0400, 13'h0200}};
        vecs[2] = '{13'h0001, 2, {13'h185A, 13'h0C2D, 13'h161B, 13'h1B00,
                                  13'h0D80, 13'h06C0, 13'h0360, 13'h01B0}};
        vecs[3] = '{13'h1000, 0, {13'h0D80, 13'h06C0, 13'h0360, 13'h01B0,
                                  13'h00D8, 13'h006C, 13'h0036, 13'h001B}};
        vecs[4] = '{13'h0002, 0, {13'h0200, 13'h0100, 13'h0080, 13'h0040,
                                  13'h0020, 13'h0010, 13'h0008, 13'h0004}};
        vecs[5] = '{13'h0000, 3, 104'd0};

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_ready", {103'd0, ready0}, 104'd1);
        check("reset_valid", {103'd0, valid0}, 104'd0);
        check("reset_last", {103'd0, last0}, 104'd0);
        check("reset_prod", prod0, 104'd0);

        for (int v = 0; v < 6; v++) begin
            run_coef(vecs[v].coef);
            check($sformatf("vec%0d_coef%h_b%0d", v, vecs[v].coef, vecs[v].k),
                  got0[vecs[v].k], vecs[v].exp);
        end

        // Unit coefficient, last batch against the model
        run_coef(13'h0001);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("unit_b3_p%0d", i), {91'd0, got0[3][i*13 +: 13]},
                  {72'd0, apow(3 * 8 + i + 1, 13, 32'h1B)});
        end

        // Stall for three cycles after batch 0
        load0 = 1'b1;
        coef0 = 13'h0001;
        step();
        load0 = 1'b0;
        en0 = 1'b1;
        step();
        check("stall_b0", prod0, vecs[0].exp);
        en0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("stall_valid%0d", s), {103'd0, valid0}, 104'd0);
            check($sformatf("stall_hold%0d", s), prod0, vecs[0].exp);
        end
        en0 = 1'b1;
        step();
        check("stall_b1", prod0, vecs[1].exp);
        check("stall_b1_valid", {103'd0, valid0}, 104'd1);
        step();
        step();
        check("stall_last", {103'd0, last0}, 104'd1);
        en0 = 1'b0;
        step();

        // Load ignored mid-run, then back-to-back load in the last_o cycle
        load0 = 1'b1;
        coef0 = 13'h0001;
        step();
        load0 = 1'b0;
        en0 = 1'b1;
        step();
        load0 = 1'b1;
        coef0 = 13'h0ABC;
        step();
        load0 = 1'b0;
        check("midload_b1", prod0, vecs[1].exp);
        step();
        check("midload_b2", prod0, vecs[2].exp);
        step();
        check("b2b_last", {103'd0, last0}, 104'd1);
        check("b2b_ready", {103'd0, ready0}, 104'd1);
        load0 = 1'b1;
        coef0 = 13'h0002;
        step();
        load0 = 1'b0;
        check("b2b_running", {103'd0, ready0}, 104'd0);
        step();
        check("b2b_b0", prod0, vecs[4].exp);
        check("b2b_b0_valid", {103'd0, valid0}, 104'd1);
        step();
        step();
        step();
        en0 = 1'b0;
        step();

        // Reset after batch 1, with load asserted alongside it
        load0 = 1'b1;
        coef0 = 13'h0001;
        step();
        load0 = 1'b0;
        en0 = 1'b1;
        step();
        step();
        check("prerst_b1", prod0, vecs[1].exp);
        rst = 1'b1;
        load0 = 1'b1;
        step();
        check("rst_ready", {103'd0, ready0}, 104'd1);
        check("rst_valid", {103'd0, valid0}, 104'd0);
        check("rst_last", {103'd0, last0}, 104'd0);
        check("rst_prod", prod0, 104'd0);
        rst = 1'b0;
        load0 = 1'b0;
        en0 = 1'b0;
        step();
        check("rst_beats_load", {103'd0, ready0}, 104'd1);

        // Sweep: M=8, POLY=1D, P=4, J=3, NCYC=2
        load1 = 1'b1;
        coef1 = 8'h53;
        step();
        load1 = 1'b0;
        en1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("m8_valid_b%0d", k), {103'd0, valid1}, 104'd1);
            check($sformatf("m8_last_b%0d", k), {103'd0, last1}, {103'd0, k == 1});
            for (int i = 0; i < 4; i++) begin
                check($sformatf("m8_b%0d_p%0d", k, i), {96'd0, prod1[i*8 +: 8]},
                      {72'd0, gmul(32'h53, apow(3 * (k * 4 + i + 1), 8, 32'h1D), 8, 32'h1D)});
            end
        end
        check("m8_ready_end", {103'd0, ready1}, 104'd1);
        en1 = 1'b0;
        step();

        // Sweep: defaults with J=5
        load2 = 1'b1;
        coef2 = 13'h0ABC;
        step();
        load2 = 1'b0;
        en2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("j5_valid_b%0d", k), {103'd0, valid2}, 104'd1);
            check($sformatf("j5_last_b%0d", k), {103'd0, last2}, {103'd0, k == 3});
            for (int i = 0; i < 8; i++) begin
                check($sformatf("j5_b%0d_p%0d", k, i), {91'd0, prod2[i*13 +: 13]},
                      {72'd0, gmul(32'hABC, apow(5 * (k * 8 + i + 1), 13, 32'h1B), 13, 32'h1B)});
            end
        end
        en2 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
